// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide front-end blocks.
//   - RV32M divide op encodings (funct3[1:0])
//   - divider front-end FSM state encoding
//   - fixed results for divide-by-zero and signed overflow
//   - small helpers for op decoding and magnitude extraction
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } div_state_e;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOTIENT  = 32'h8000_0000;
    localparam logic [31:0] OVF_REMAINDER = 32'h0000_0000;
    localparam logic [31:0] INT32_MIN     = 32'h8000_0000;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // INT32_MIN maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Post-divider sign correction and result select.
//   op_i       : operation being completed
//   neg_q_i    : negate the quotient
//   neg_r_i    : negate the remainder
//   div_out_i  : {quotient, remainder} magnitudes from the unsigned divider
//   result_o   : corrected quotient (DIV/DIVU) or remainder (REM/REMU)
module div_sign_fix
    import muldiv_pkg::*;
(
    input  div_op_e     op_i,
    input  logic        neg_q_i,
    input  logic        neg_r_i,
    input  logic [63:0] div_out_i,
    output logic [31:0] result_o
);

    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        quot = div_out_i[63:32];
        rem  = div_out_i[31:0];
        if (neg_q_i) begin
            quot = ~quot + 32'd1;
        end
        if (neg_r_i) begin
            rem = ~rem + 32'd1;
        end
        result_o = op_is_rem(op_i) ? rem : quot;
    end

endmodule

// File: rtl/div_frontend.sv
// RV32M divide front-end: accepts DIV/DIVU/REM/REMU requests, resolves
// divide-by-zero and signed overflow locally, otherwise feeds operand
// magnitudes to an external unsigned divider_32 and sign-corrects its output.
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_op/req_rs1/req_rs2 : request handshake
//   kill                                       : flush of the in-flight op
//   resp_valid/resp_ready/resp_result          : result handshake
//   div_start/div_dividend/div_divisor         : to the divider
//   div_rdy/div_out                            : from the divider
module div_frontend
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        kill,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_rdy,
    input  logic [63:0] div_out
);

    div_state_e  state_q, state_d;
    div_op_e     op_q, op_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] result_q, result_d;

    div_op_e     req_op_e;
    logic        req_signed;
    logic        req_rem;
    logic        rs2_zero;
    logic        req_ovf;
    logic [31:0] fixed_result;

    assign req_op_e   = div_op_e'(req_op);
    assign req_signed = op_is_signed(req_op_e);
    assign req_rem    = op_is_rem(req_op_e);
    assign rs2_zero   = (req_rs2 == '0);
    assign req_ovf    = req_signed && (req_rs1 == INT32_MIN) && (req_rs2 == '1);

    div_sign_fix u_sign_fix (
        .op_i      (op_q),
        .neg_q_i   (neg_quot_q),
        .neg_r_i   (neg_rem_q),
        .div_out_i (div_out),
        .result_o  (fixed_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_DIV;
            dividend_q <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        unique case (state_q)
            ST_IDLE: begin
                // kill in IDLE suppresses acceptance for that cycle only.
                if (req_valid && !kill) begin
                    op_d       = req_op_e;
                    dividend_d = req_signed ? abs32(req_rs1) : req_rs1;
                    divisor_d  = req_signed ? abs32(req_rs2) : req_rs2;
                    neg_quot_d = req_signed && (req_rs1[31] ^ req_rs2[31]) && !rs2_zero;
                    neg_rem_d  = req_signed && req_rs1[31];
                    if (rs2_zero) begin
                        result_d = req_rem ? req_rs1 : DIV0_QUOTIENT;
                        state_d  = ST_DONE;
                    end else if (req_ovf) begin
                        result_d = req_rem ? OVF_REMAINDER : OVF_QUOTIENT;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (div_rdy) begin
                    if (kill) begin
                        state_d = ST_IDLE;
                    end else begin
                        result_d = fixed_result;
                        state_d  = ST_DONE;
                    end
                end else if (kill) begin
                    // Divider keeps running; wait for its done pulse.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (kill || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_DONE);
    assign resp_result  = result_q;
    assign div_start    = (state_q == ST_BUSY) && !div_rdy;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_frontend.sv
module tb_div_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_rdy;
    logic [63:0] div_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_frontend dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .kill         (kill),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_rdy      (div_rdy),
        .div_out      (div_out)
    );

    // Behavioural divider_32: once started it runs 32 cycles regardless of
    // div_start, then pulses div_rdy with {a/b, a%b} of the latched operands.
    logic        dv_busy;
    logic        dv_rdy;
    int          dv_cnt;
    logic [31:0] dv_a, dv_b;
    logic [63:0] dv_out;
    logic        spur_rdy;
    int          start_cnt;

    assign div_rdy = dv_rdy | spur_rdy;
    assign div_out = dv_out;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_busy <= 1'b0;
            dv_rdy  <= 1'b0;
            dv_cnt  <= 0;
            dv_a    <= '0;
            dv_b    <= '0;
            dv_out  <= '0;
        end else if (dv_rdy) begin
            dv_rdy <= 1'b0;
        end else if (dv_busy) begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt == 31) begin
                dv_busy <= 1'b0;
                dv_rdy  <= 1'b1;
                if (dv_b != 0) dv_out <= {dv_a / dv_b, dv_a % dv_b};
                else           dv_out <= {32'hFFFF_FFFF, dv_a};
            end
        end else if (div_start) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 1;
            dv_a    <= div_dividend;
            dv_b    <= div_divisor;
        end
    end

    initial start_cnt = 0;
    always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

    // Architectural RV32M result, straight from the ISA rules.
    function automatic logic [31:0] ref_rv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int   sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op == 2'b00) begin
            if (b == 0)   return 32'hFFFF_FFFF;
            else if (ovf) return 32'h8000_0000;
            else          return 32'(sa / sb);
        end else if (op == 2'b01) begin
            if (b == 0) return 32'hFFFF_FFFF;
            else        return a / b;
        end else if (op == 2'b10) begin
            if (b == 0)   return a;
            else if (ovf) return 32'h0;
            else          return 32'(sa % sb);
        end else begin
            if (b == 0) return a;
            else        return a % b;
        end
    endfunction

    function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for the result, hold resp_ready low
    // for 'hold' cycles, then hand the result off.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          sc0;
        exp     = ref_rv(op, a, b);
        exp_lat = is_fast(op, a, b) ? 1 : 34;
        sc0     = start_cnt;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_valid = 1'b1;
        check({tag, " ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, resp_result, exp);
        if (exp_lat == 1) check({tag, " no div_start"}, start_cnt - sc0, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " held valid"}, resp_valid, 1);
            check({tag, " held result"}, resp_result, exp);
            check({tag, " held ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, " back idle"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_rs1    = '0;
        req_rs2    = '0;
        kill       = 1'b0;
        resp_ready = 1'b0;
        spur_rdy   = 1'b0;
        step();
        step();
        check("reset outputs", {req_ready, resp_valid, div_start}, 3'b100);
        check("reset result", resp_result, 0);
        reset = 1'b1;
        step();
        check("post-reset ready", req_ready, 1);

        // Signed divide through the divider, with magnitude check on the way.
        req_op = 2'b00; req_rs1 = 32'd100; req_rs2 = 32'hFFFF_FFF9; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("DIV mags", {div_dividend, div_divisor}, {32'd100, 32'd7});
        check("DIV start", div_start, 1);
        n = 1;
        while (!resp_valid && n < 200) begin step(); n++; end
        check("DIV 100/-7 latency", n, 34);
        check("DIV 100/-7 result", resp_result, 32'hFFFF_FFF2);
        resp_ready = 1'b1; step(); resp_ready = 1'b0;

        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0, "REM -100/7");
        do_op(2'b11, 32'hFFFF_FFFF, 32'd16, 0, "REMU ffffffff/16");
        do_op(2'b01, 32'd5, 32'd0, 0, "DIVU 5/0");
        do_op(2'b10, 32'd5, 32'd0, 0, "REM 5/0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "DIV ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "REM ovf");
        do_op(2'b01, 32'd1234567, 32'd89, 5, "DIVU hold5");

        // kill on the 10th BUSY cycle -> DRAIN until the divider finishes.
        req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd7; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("drain outputs", {req_ready, resp_valid, div_start}, 3'b000);
        n = 0;
        while (!div_rdy && n < 100) begin
            check("drain hold", {req_ready, resp_valid}, 2'b00);
            step();
            n++;
        end
        check("drain saw div_rdy", div_rdy, 1);
        step();
        check("drain exit ready", {req_ready, resp_valid}, 2'b10);
        do_op(2'b01, 32'd9, 32'd3, 0, "DIVU 9/3 after drain");

        // kill coinciding with div_rdy discards the result.
        req_op = 2'b00; req_rs1 = 32'd77; req_rs2 = 32'd7; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!div_rdy && n < 100) begin step(); n++; end
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill+rdy idle", {req_ready, resp_valid}, 2'b10);

        // kill in DONE drops the result.
        req_op = 2'b01; req_rs1 = 32'd5; req_rs2 = 32'd0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("done before kill", resp_valid, 1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill in done", {req_ready, resp_valid}, 2'b10);

        // kill in IDLE blocks acceptance.
        req_op = 2'b01; req_rs1 = 32'd50; req_rs2 = 32'd5; req_valid = 1'b1; kill = 1'b1;
        step();
        req_valid = 1'b0; kill = 1'b0;
        check("kill in idle", {req_ready, resp_valid, div_start}, 3'b100);

        // Stray div_rdy in IDLE is ignored.
        spur_rdy = 1'b1;
        step();
        spur_rdy = 1'b0;
        check("stray rdy idle", {req_ready, resp_valid}, 2'b10);
        do_op(2'b00, 32'hFFFF_FF00, 32'd16, 1, "DIV after stray");

        // Randomized operations against the ISA model.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = $urandom;
            case ($urandom_range(7, 0))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(16, 1));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(16, 1));
                default: rb = $urandom;
            endcase
            if ($urandom_range(5, 0) == 0) ra = 32'h8000_0000;
            do_op(rop, ra, rb, int'($urandom_range(2, 0)), "rand");
        end

        // Reset asserted mid-BUSY.
        req_op = 2'b00; req_rs1 = 32'hFFFF_F000; req_rs2 = 32'd3; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        check("busy before reset", div_start, 1);
        reset = 1'b0;
        #1;
        check("mid reset outputs", {req_ready, resp_valid, div_start}, 3'b100);
        check("mid reset result", resp_result, 0);
        check("mid reset operands", {div_dividend, div_divisor}, 64'd0);
        step();
        reset = 1'b1;
        step();
        do_op(2'b11, 32'd100, 32'd7, 0, "REMU after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_frontend.md
DIV_FRONTEND -- requirements
Module: div_frontend

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; one clock domain.
REQ-003 req_valid  input  1  operation request.
REQ-004 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-005 req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-006 req_rs1  input  32  dividend operand.
REQ-007 req_rs2  input  32  divisor operand.
REQ-008 kill  input  1  pipeline flush; abandons the in-flight operation.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_result  output  32  final quotient or remainder.
REQ-012 div_start  output  1  start/hold to unsigned divider_32.
REQ-013 div_dividend, div_divisor  output  32 each  magnitudes to the divider, stable while div_start high.
REQ-014 div_rdy  input  1  divider done pulse.
REQ-015 div_out  input  64  {quotient[63:32], remainder[31:0]} from the divider.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, DRAIN, DONE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-017 On accept, the block SHALL register op, |rs1|, |rs2| (absolute value for DIV/REM, raw for DIVU/REMU), neg_q = signed & (rs1[31]^rs2[31]) & (rs2!=0), and neg_r = signed & rs1[31].
REQ-018 Divide-by-zero (rs2==0): go directly to DONE; quotient 0xFFFFFFFF, remainder = rs1; divider not started.
REQ-019 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): go directly to DONE; quotient 0x80000000, remainder 0; divider not started.
REQ-020 Otherwise go to BUSY; div_start SHALL equal (state==BUSY) & ~div_rdy (combinational), so it drops in the div_rdy cycle and the divider returns to idle.
REQ-021 In BUSY on a div_rdy edge, the block SHALL capture div_out, apply two's-complement negation to the quotient if neg_q and to the remainder if neg_r, select quotient (DIV/DIVU) or remainder (REM/REMU) into resp_result, and enter DONE.
REQ-022 The block SHALL NOT count divider cycles; completion is signalled only by div_rdy (33 BUSY cycles with the current divider).
REQ-023 DONE: resp_valid=1 and resp_result held stable until resp_valid & resp_ready, then IDLE; req_ready=0 in DONE.
REQ-024 Fast-path latency: resp_valid in the cycle after accept.
REQ-025 kill in BUSY without div_rdy SHALL move to DRAIN; kill in BUSY with div_rdy SHALL move to IDLE and discard the result.
REQ-026 DRAIN: div_start=0, req_ready=0, resp_valid=0; exit to IDLE on div_rdy.
REQ-027 kill in DONE SHALL drop the result and go to IDLE; kill in IDLE SHALL block acceptance that cycle.
REQ-028 div_rdy outside BUSY/DRAIN SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL force IDLE, req_ready=1, resp_valid=0, div_start=0, resp_result=0, and all operand/sign registers to 0, including mid-operation.
REQ-030 The parent SHALL reset the divider on the same reset net, so no DRAIN is needed after reset.

Structure
REQ-031 Op encodings and FSM state encodings SHALL live in the shared muldiv package; the overflow and divide-by-zero result constants SHALL live there too.
REQ-032 The block SHALL instantiate no divider; it connects to divider_32 at the parent level.
REQ-033 One sub-module, div_sign_fix (combinational negate/select), is natural.

Verification
REQ-034 DIV 100 / -7 -> resp_result 0xFFFFFFF2 (-14), resp_valid 34 cycles after accept.
REQ-035 REM -100 / 7 -> 0xFFFFFFFE (-2); REMU 0xFFFFFFFF / 16 -> 0x0000000F.
REQ-036 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with resp_valid in the cycle after accept; div_start never high.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-038 kill on the 10th BUSY cycle -> DRAIN, req_ready low until the divider's div_rdy, no resp_valid; a following DIVU 9/3 then returns 3.
REQ-039 resp_ready held low 5 cycles in DONE -> resp_result stable and resp_valid held; reset asserted mid-BUSY -> all outputs at their reset values immediately.
